one_bit_alu: RTL and testbench

- Registered bit-sliced ALU: WIDTH identical one-bit slices, each a full adder, a 2:1 b-invert mux and an 8:1 result mux.
- Carry ripples from slice 0 (LSB) to slice WIDTH-1.
- Results and carry-out are captured in output registers on the clock.
- Leaf datapath element of the CPU execute stage; WIDTH=1 is the single-slice building block.

---
 rtl/one_bit_alu.sv | 110 +++++++++++
 tb/tb_one_bit_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/one_bit_alu.sv
// Registered bit-sliced ALU: WIDTH ripple-carry slices; 1-cycle latency; loads only when en=1 (no backpressure).
// Optional macro ALU_FLAGS_EN adds registered zero/negative/overflow outputs.

module one_bit_alu_slice (
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c,
    input  logic [2:0] i_sel,
    output logic       o_res,
    output logic       o_c
);
    logic w_bm;
    logic w_s;

    assign w_bm = i_sel[0] ? ~i_b : i_b;
    assign w_s  = i_a ^ w_bm ^ i_c;
    assign o_c  = (i_a & w_bm) | (i_a & i_c) | (w_bm & i_c);

    always_comb begin
        o_res = 1'b0;
        case (i_sel)
            3'b000:  o_res = i_b;
            3'b001:  o_res = 1'b0;
            3'b010:  o_res = w_s;
            3'b011:  o_res = w_s;
            3'b100:  o_res = i_a & i_b;
            3'b101:  o_res = i_a | i_b;
            3'b110:  o_res = i_a ^ i_b;
            default: o_res = 1'b0;
        endcase
    end
endmodule

module one_bit_alu #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             cout
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             overflow
`endif
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;

    assign w_c[0] = cin;

    // Carry ripples LSB to MSB; the adder runs for every opcode.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        one_bit_alu_slice u_slice (
            .i_a   (a[gi]),
            .i_b   (b[gi]),
            .i_c   (w_c[gi]),
            .i_sel (sel),
            .o_res (w_res[gi]),
            .o_c   (w_c[gi+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_cout <= 1'b0;
        end else if (en) begin
            r_out  <= w_res;
            r_cout <= w_c[WIDTH];
        end
    end

    assign out  = r_out;
    assign cout = r_cout;

`ifdef ALU_FLAGS_EN
    logic w_ovf;
    logic r_zero;
    logic r_negative;
    logic r_overflow;

    // Signed overflow only has meaning for the add/sub opcodes.
    assign w_ovf = (sel[2:1] == 2'b01) ? (w_c[WIDTH] ^ w_c[WIDTH-1]) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else if (en) begin
            r_zero     <= (w_res == '0);
            r_negative <= w_res[WIDTH-1];
            r_overflow <= w_ovf;
        end
    end

    assign zero     = r_zero;
    assign negative = r_negative;
    assign overflow = r_overflow;
`endif
endmodule

// File: tb/tb_one_bit_alu.sv
// Bench for one_bit_alu at WIDTH=1 and WIDTH=8 against an arithmetic reference model.
module tb_one_bit_alu;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cin;
    logic [2:0] sel;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       out1, cout1;
    logic [7:0] out8;
    logic       cout8;
`ifdef ALU_FLAGS_EN
    logic       z1, n1, v1, z8, n8, v8;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] e1_out, e8_out;
    logic        e1_c, e1_z, e1_n, e1_v;
    logic        e8_c, e8_z, e8_n, e8_v;

    always #5 clk = ~clk;

    one_bit_alu #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a1), .b(b1), .cin(cin), .sel(sel),
        .out(out1), .cout(cout1)
`ifdef ALU_FLAGS_EN
        , .zero(z1), .negative(n1), .overflow(v1)
`endif
    );

    one_bit_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a8), .b(b8), .cin(cin), .sel(sel),
        .out(out8), .cout(cout8)
`ifdef ALU_FLAGS_EN
        , .zero(z8), .negative(n8), .overflow(v8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, carry read from bit w of the sum.
    task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                         input logic c, input logic [2:0] s,
                         output logic [63:0] res, output logic co,
                         output logic z, output logic n, output logic v);
        logic [63:0] mask, am, bm, full, sum;
        mask = (64'd1 << w) - 64'd1;
        am   = av & mask;
        bm   = s[0] ? (~bv & mask) : (bv & mask);
        full = am + bm + 64'(c);
        sum  = full & mask;
        co   = full[w];
        case (s)
            3'd0: res = bv & mask;
            3'd2, 3'd3: res = sum;
            3'd4: res = am & bv;
            3'd5: res = (am | bv) & mask;
            3'd6: res = (am ^ bv) & mask;
            default: res = 64'd0;
        endcase
        z = (res == 64'd0);
        n = res[w-1];
        v = (s == 3'd2 || s == 3'd3) && (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
    endtask

    task automatic clear_model();
        e1_out = 0; e1_c = 0; e1_z = 0; e1_n = 0; e1_v = 0;
        e8_out = 0; e8_c = 0; e8_z = 0; e8_n = 0; e8_v = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w1_out"},  64'(out1),  e1_out);
        check({tag, ".w1_cout"}, 64'(cout1), 64'(e1_c));
        check({tag, ".w8_out"},  64'(out8),  e8_out);
        check({tag, ".w8_cout"}, 64'(cout8), 64'(e8_c));
`ifdef ALU_FLAGS_EN
        check({tag, ".w1_zero"}, 64'(z1), 64'(e1_z));
        check({tag, ".w1_neg"},  64'(n1), 64'(e1_n));
        check({tag, ".w1_ovf"},  64'(v1), 64'(e1_v));
        check({tag, ".w8_zero"}, 64'(z8), 64'(e8_z));
        check({tag, ".w8_neg"},  64'(n8), 64'(e8_n));
        check({tag, ".w8_ovf"},  64'(v8), 64'(e8_v));
`endif
    endtask

    task automatic step(input string tag, input logic e, input logic [7:0] av8, input logic [7:0] bv8,
                        input logic av1, input logic bv1, input logic cv, input logic [2:0] sv);
        en = e; a8 = av8; b8 = bv8; a1 = av1; b1 = bv1; cin = cv; sel = sv;
        @(posedge clk);
        if (e && rst_n) begin
            model(1, 64'(av1), 64'(bv1), cv, sv, e1_out, e1_c, e1_z, e1_n, e1_v);
            model(8, 64'(av8), 64'(bv8), cv, sv, e8_out, e8_c, e8_z, e8_n, e8_v);
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; cin = 1'b0; sel = 3'd0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        clear_model();
        #3;
        check_all("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 add
        step("add1_001", 1'b1, r8(), r8(), 1'b0, 1'b0, 1'b1, 3'b010);
        check("add1_001_out_const", 64'(out1), 64'd1);
        check("add1_001_cout_const", 64'(cout1), 64'd0);
        step("add1_101", 1'b1, r8(), r8(), 1'b1, 1'b0, 1'b1, 3'b010);
        step("add1_110", 1'b1, r8(), r8(), 1'b1, 1'b1, 1'b0, 3'b010);
        check("add1_110_cout_const", 64'(cout1), 64'd1);
        // WIDTH=1 sub
        step("sub1_001", 1'b1, r8(), r8(), 1'b0, 1'b0, 1'b1, 3'b011);
        step("sub1_101", 1'b1, r8(), r8(), 1'b1, 1'b0, 1'b1, 3'b011);
        check("sub1_101_out_const", 64'(out1), 64'd1);
        // WIDTH=1 logic and pass/zero opcodes
        step("and1", 1'b1, r8(), r8(), 1'b0, 1'b1, r1(), 3'b100);
        step("or1",  1'b1, r8(), r8(), 1'b1, 1'b1, r1(), 3'b101);
        step("xor1a", 1'b1, r8(), r8(), 1'b1, 1'b1, r1(), 3'b110);
        step("xor1b", 1'b1, r8(), r8(), 1'b0, 1'b1, r1(), 3'b110);
        step("passb", 1'b1, r8(), r8(), r1(), 1'b1, r1(), 3'b000);
        step("zero001", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 3'b001);
        check("zero001_out_const", 64'(out8), 64'd0);
        step("zero111", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 3'b111);

        // WIDTH=8 ripple boundaries
        step("add8_ff", 1'b1, 8'hFF, 8'h01, r1(), r1(), 1'b0, 3'b010);
        check("add8_ff_out_const", 64'(out8), 64'h00);
        check("add8_ff_cout_const", 64'(cout8), 64'd1);
        step("sub8_80", 1'b1, 8'h80, 8'h01, r1(), r1(), 1'b1, 3'b011);
        check("sub8_80_out_const", 64'(out8), 64'h7F);
        check("sub8_80_cout_const", 64'(cout8), 64'd1);

        // Hold with en=0 and changing inputs
        step("load", 1'b1, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b0, r8(), r8(), r1(), r1(), r1(), 3'($urandom));

        // Asynchronous reset mid-stream, then reset winning over an en=1 edge
        step("pre_rst", 1'b1, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0, 3'b101);
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("async_rst");
        step("rst_vs_en", 1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, 3'b010);
        rst_n = 1'b1;
        step("post_rst_hold", 1'b0, r8(), r8(), r1(), r1(), r1(), 3'($urandom));

        // Random traffic, including en=0 cycles
        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(0, 3) != 0), r8(), r8(), r1(), r1(), r1(), 3'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
